// File: rtl/burst_mem_pkg.sv
// ---------------------------------------------------------------------------
// burst_mem_pkg
// Shared definitions for the burst memory master: default bus widths and the
// controller state encoding.
// ---------------------------------------------------------------------------
package burst_mem_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_LEN_WIDTH  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage : burst_mem_pkg

// File: rtl/burst_mem_master.sv
// ---------------------------------------------------------------------------
// burst_mem_master
// Accepts a single burst command (start address + beat count) and drives a
// single-port synchronous memory, one beat per cycle.
//   Write bursts: beats are taken from a valid/ready write-data stream and
//                 written straight through; the burst stalls while no data.
//   Read bursts:  one read address per cycle; memory data returns one cycle
//                 later and is forwarded on an unthrottled read-data stream.
// A one-cycle FLUSH after the last read address collects the final beat, and
// DONE pulses o_done for one cycle before returning to IDLE. Zero-length
// commands go straight to DONE. Addresses wrap modulo 2^ADDR_WIDTH.
//
// Ports
//   i_clk, i_rst_n                         clock, async active-low reset
//   i_cmd_valid/o_cmd_ready                command handshake (ready in IDLE)
//   i_cmd_write, i_cmd_addr, i_cmd_len     burst direction, start, beats
//   i_wdata_valid/o_wdata_ready/i_wdata    write-data stream
//   o_rdata_valid/o_rdata                  read-data stream (no backpressure)
//   o_busy, o_done                         not-idle flag, completion pulse
//   o_mem_wr_en/o_mem_rd_en/o_mem_address/o_mem_wr_data, i_mem_rd_data
//                                          single-port memory interface
// ---------------------------------------------------------------------------
module burst_mem_master
  import burst_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,

  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,

  input  logic                  i_wdata_valid,
  output logic                  o_wdata_ready,
  input  logic [DATA_WIDTH-1:0] i_wdata,

  output logic                  o_rdata_valid,
  output logic [DATA_WIDTH-1:0] o_rdata,

  output logic                  o_busy,
  output logic                  o_done,

  output logic                  o_mem_wr_en,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_wr_data,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;
  logic                  rd_valid_q;

  logic                  cmd_accept;
  logic                  wr_beat;
  logic                  last_beat;

  assign cmd_accept = i_cmd_valid && o_cmd_ready;
  assign wr_beat    = (state_q == ST_WRITE) && i_wdata_valid;
  assign last_beat  = (count_q == LEN_WIDTH'(1));

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of process ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          if (i_cmd_len == '0) begin
            state_d = ST_DONE;
          end else if (i_cmd_write) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_WRITE: if (wr_beat && last_beat) state_d = ST_DONE;
      ST_READ:  if (last_beat) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode (Moore, except write enable which follows the data stream)
  // -------------------------------------------------------------------------
  always_comb begin
    o_cmd_ready   = 1'b0;
    o_wdata_ready = 1'b0;
    o_mem_wr_en   = 1'b0;
    o_mem_rd_en   = 1'b0;
    o_busy        = 1'b1;
    o_done        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        o_busy      = 1'b0;
      end
      ST_WRITE: begin
        o_wdata_ready = 1'b1;
        o_mem_wr_en   = i_wdata_valid;
      end
      ST_READ:  o_mem_rd_en = 1'b1;
      ST_FLUSH: ;
      ST_DONE:  o_done = 1'b1;
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  assign o_mem_address = addr_q;
  assign o_mem_wr_data = i_wdata;
  assign o_rdata_valid = rd_valid_q;
  assign o_rdata       = i_mem_rd_data;

  // -------------------------------------------------------------------------
  // Address / remaining-beat counters
  // -------------------------------------------------------------------------
  // The address advances only on an actual memory access, so a write stall
  // holds both the address and the count; the add wraps naturally.
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    if (cmd_accept) begin
      addr_d  = i_cmd_addr;
      count_d = i_cmd_len;
    end else if (o_mem_wr_en || o_mem_rd_en) begin
      addr_d  = addr_q + ADDR_WIDTH'(1);
      count_d = count_q - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      count_q    <= count_d;
      // Memory read data is valid one cycle after the read enable.
      rd_valid_q <= o_mem_rd_en;
    end
  end

endmodule : burst_mem_master

// File: tb/tb_burst_mem_master.sv
// ---------------------------------------------------------------------------
// tb_burst_mem_master
// Scoreboard bench: stimulus tasks push expected memory accesses, read data
// and completion timing into queues; a monitor on the falling edge pops and
// compares whenever the DUT presents an access, read beat or done pulse.
// ---------------------------------------------------------------------------
module tb_burst_mem_master;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic       i_cmd_write;
  logic [7:0] i_cmd_addr;
  logic [7:0] i_cmd_len;
  logic       i_wdata_valid;
  logic       o_wdata_ready;
  logic [7:0] i_wdata;
  logic       o_rdata_valid;
  logic [7:0] o_rdata;
  logic       o_busy;
  logic       o_done;
  logic       o_mem_wr_en;
  logic       o_mem_rd_en;
  logic [7:0] o_mem_address;
  logic [7:0] o_mem_wr_data;
  logic [7:0] i_mem_rd_data;

  burst_mem_master #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8),
    .LEN_WIDTH (8)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_write   (i_cmd_write),
    .i_cmd_addr    (i_cmd_addr),
    .i_cmd_len     (i_cmd_len),
    .i_wdata_valid (i_wdata_valid),
    .o_wdata_ready (o_wdata_ready),
    .i_wdata       (i_wdata),
    .o_rdata_valid (o_rdata_valid),
    .o_rdata       (o_rdata),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_mem_wr_en   (o_mem_wr_en),
    .o_mem_rd_en   (o_mem_rd_en),
    .o_mem_address (o_mem_address),
    .o_mem_wr_data (o_mem_wr_data),
    .i_mem_rd_data (i_mem_rd_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------------------------------------------------------------------
  // Memory model: synchronous write, registered read (one-cycle latency)
  // ---------------------------------------------------------------------------
  logic [7:0] mem [256];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'hFE] = 8'h11;
    mem[8'hFF] = 8'h22;
    mem[8'h00] = 8'h33;
    i_mem_rd_data = 8'h00;
  end

  always @(posedge i_clk) begin
    if (o_mem_wr_en) mem[o_mem_address] <= o_mem_wr_data;
    if (o_mem_rd_en) i_mem_rd_data <= mem[o_mem_address];
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;

  typedef struct {
    bit from_accept;  // latency measured from command accept, else last access
    int lat;
  } done_t;

  acc_t       exp_acc[$];
  logic [7:0] exp_rdata[$];
  done_t      exp_done[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  int accept_cyc   = 0;
  int last_acc_cyc = 0;
  bit first_pending = 1'b0;

  always @(negedge i_clk) begin
    if (i_cmd_valid && o_cmd_ready) begin
      accept_cyc    = cyc;
      first_pending = 1'b1;
    end

    if (o_mem_wr_en || o_mem_rd_en) begin
      acc_t e;
      check("wr_rd_exclusive", 32'(o_mem_wr_en && o_mem_rd_en), 32'd0);
      if (first_pending) begin
        check("first_access_latency", 32'(cyc - accept_cyc), 32'd1);
        first_pending = 1'b0;
      end
      if (exp_acc.size() == 0) begin
        check("spurious_access", 32'd1, 32'd0);
      end else begin
        e = exp_acc.pop_front();
        check("access_kind", 32'(o_mem_wr_en), 32'(e.wr));
        check("access_addr", 32'(o_mem_address), 32'(e.addr));
        if (e.wr) check("write_data", 32'(o_mem_wr_data), 32'(e.data));
      end
      last_acc_cyc = cyc;
    end

    if (o_rdata_valid) begin
      if (exp_rdata.size() == 0) check("spurious_rdata", 32'd1, 32'd0);
      else check("rdata", 32'(o_rdata), 32'(exp_rdata.pop_front()));
    end

    if (o_done) begin
      done_t d;
      if (exp_done.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        d = exp_done.pop_front();
        if (d.from_accept) check("done_latency_accept", 32'(cyc - accept_cyc), 32'(d.lat));
        else check("done_latency_last", 32'(cyc - last_acc_cyc), 32'(d.lat));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks
  // ---------------------------------------------------------------------------
  // Returns 1 time unit after the edge that accepted the command.
  task automatic issue_cmd(input logic w, input logic [7:0] a, input logic [7:0] l);
    int guard = 0;
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b1;
    i_cmd_write = w;
    i_cmd_addr  = a;
    i_cmd_len   = l;
    @(negedge i_clk);
    while (!o_cmd_ready && guard < 50) begin
      @(negedge i_clk);
      guard++;
    end
    if (guard >= 50) check("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge i_clk);
    while (o_busy && guard < 100) begin
      @(negedge i_clk);
      guard++;
    end
    if (guard >= 100) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] len,
                          input logic [7:0] d0, input int stall_at, input int stall_n);
    int beat    = 0;
    int stalled = 0;
    int guard   = 0;
    for (int i = 0; i < int'(len); i++)
      exp_acc.push_back('{1'b1, 8'(int'(addr) + i), 8'(int'(d0) + i)});
    if (len == 8'd0) exp_done.push_back('{1'b1, 1});
    else exp_done.push_back('{1'b0, 1});
    issue_cmd(1'b1, addr, len);
    while (beat < int'(len) && guard < 200) begin
      if (beat == stall_at && stalled < stall_n) begin
        // Withhold data and offer a competing command, which must be ignored.
        i_wdata_valid = 1'b0;
        i_cmd_valid   = 1'b1;
        i_cmd_write   = 1'b0;
        i_cmd_addr    = 8'h80;
        i_cmd_len     = 8'd2;
        @(negedge i_clk);
        check("busy_cmd_ready", 32'(o_cmd_ready), 32'd0);
        check("busy_flag", 32'(o_busy), 32'd1);
        stalled++;
      end else begin
        i_cmd_valid   = 1'b0;
        i_wdata_valid = 1'b1;
        i_wdata       = 8'(int'(d0) + beat);
        @(negedge i_clk);
        if (o_wdata_ready) beat++;
      end
      @(posedge i_clk); #1;
      guard++;
    end
    if (guard >= 200) check("write_timeout", 32'd1, 32'd0);
    i_wdata_valid = 1'b0;
    i_cmd_valid   = 1'b0;
    wait_idle();
  endtask

  // Caller pushes the hand-computed read data before calling.
  task automatic do_read(input logic [7:0] addr, input logic [7:0] len);
    for (int i = 0; i < int'(len); i++)
      exp_acc.push_back('{1'b0, 8'(int'(addr) + i), 8'h00});
    if (len == 8'd0) exp_done.push_back('{1'b1, 1});
    else exp_done.push_back('{1'b0, 2});
    issue_cmd(1'b0, addr, len);
    wait_idle();
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    i_rst_n       = 1'b0;
    i_cmd_valid   = 1'b0;
    i_cmd_write   = 1'b0;
    i_cmd_addr    = 8'h00;
    i_cmd_len     = 8'h00;
    i_wdata_valid = 1'b0;
    i_wdata       = 8'h00;

    // Reset state
    #3;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_rdata_valid", 32'(o_rdata_valid), 32'd0);
    check("rst_wr_en", 32'(o_mem_wr_en), 32'd0);
    check("rst_rd_en", 32'(o_mem_rd_en), 32'd0);
    check("rst_address", 32'(o_mem_address), 32'd0);
    check("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // Continuous write burst: A0..A7 to 01..08
    do_write(8'h01, 8'd8, 8'hA0, -1, 0);

    // Read it back
    exp_rdata.push_back(8'hA0); exp_rdata.push_back(8'hA1);
    exp_rdata.push_back(8'hA2); exp_rdata.push_back(8'hA3);
    exp_rdata.push_back(8'hA4); exp_rdata.push_back(8'hA5);
    exp_rdata.push_back(8'hA6); exp_rdata.push_back(8'hA7);
    do_read(8'h01, 8'd8);

    // Write with a two-cycle data stall before beat 2
    do_write(8'h40, 8'd4, 8'hC0, 2, 2);
    exp_rdata.push_back(8'hC0); exp_rdata.push_back(8'hC1);
    exp_rdata.push_back(8'hC2); exp_rdata.push_back(8'hC3);
    do_read(8'h40, 8'd4);

    // Address wrap: FE, FF, 00 (preloaded 11, 22, 33)
    exp_rdata.push_back(8'h11); exp_rdata.push_back(8'h22); exp_rdata.push_back(8'h33);
    do_read(8'hFE, 8'd3);

    // Zero-length commands
    do_write(8'h10, 8'd0, 8'h00, -1, 0);
    do_read(8'h20, 8'd0);

    // Reset during beat 3 of a len-10 read: beats 1 and 2 issue, only the
    // first beat's data returns, and there is no done pulse.
    exp_acc.push_back('{1'b0, 8'h01, 8'h00});
    exp_acc.push_back('{1'b0, 8'h02, 8'h00});
    exp_rdata.push_back(8'hA0);
    issue_cmd(1'b0, 8'h01, 8'd10);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_done", 32'(o_done), 32'd0);
    check("abort_rdata_valid", 32'(o_rdata_valid), 32'd0);
    check("abort_wr_en", 32'(o_mem_wr_en), 32'd0);
    check("abort_rd_en", 32'(o_mem_rd_en), 32'd0);
    check("abort_address", 32'(o_mem_address), 32'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    check("post_abort_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check("post_abort_busy", 32'(o_busy), 32'd0);

    // Every expected event must have been observed
    check("pending_access", 32'(exp_acc.size()), 32'd0);
    check("pending_rdata", 32'(exp_rdata.size()), 32'd0);
    check("pending_done", 32'(exp_done.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_burst_mem_master

// File: doc/burst_mem_master.md
BURST_MEM_MASTER -- requirements
Module: burst_mem_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, memory data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, memory address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, burst length counter width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: i_clk input 1 is the clock; i_rst_n input 1 is the async active-low reset.
REQ-005 i_cmd_valid  input  1  command request.
REQ-006 o_cmd_ready  output  1  high only in IDLE; command accepted when valid and ready.
REQ-007 i_cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-008 i_cmd_addr  input  ADDR_WIDTH  burst start address.
REQ-009 i_cmd_len  input  LEN_WIDTH  number of beats.
REQ-010 i_wdata_valid / o_wdata_ready / i_wdata  in / out / in  1 / 1 / DATA_WIDTH  write-data stream.
REQ-011 o_rdata_valid / o_rdata  out / out  1 / DATA_WIDTH  read-data stream, no backpressure.
REQ-012 o_busy  output  1  high in any state other than IDLE.
REQ-013 o_done  output  1  single-cycle pulse at burst completion.
REQ-014 o_mem_wr_en, o_mem_rd_en, o_mem_address, o_mem_wr_data  outputs  1, 1, ADDR_WIDTH, DATA_WIDTH  single-port memory controls.
REQ-015 i_mem_rd_data  input  DATA_WIDTH  memory read data, valid one cycle after o_mem_rd_en.

Function
REQ-016 SHALL implement the FSM states IDLE, WRITE, READ, FLUSH and DONE.
REQ-017 IDLE: on accept, latch address and length; go to WRITE or READ per i_cmd_write; if i_cmd_len = 0, go directly to DONE with no memory access.
REQ-018 WRITE: o_wdata_ready = 1; on each beat (i_wdata_valid = 1), assert o_mem_wr_en for that cycle with o_mem_address = the current address and o_mem_wr_data = i_wdata (combinational pass-through); increment the address and decrement the remaining count.
REQ-019 WRITE stall: while i_wdata_valid = 0, hold o_mem_wr_en low and keep the address and count unchanged.
REQ-020 WRITE: after the last beat, go to DONE.
REQ-021 READ: assert o_mem_rd_en every cycle, with one address per cycle; after issuing the last address, go to FLUSH.
REQ-022 Read data: o_rdata_valid SHALL be high exactly one cycle after each o_mem_rd_en, with o_rdata = i_mem_rd_data.
REQ-023 FLUSH: lasts one cycle to capture the final read beat, then goes to DONE.
REQ-024 DONE: o_done = 1 for exactly one cycle, then return to IDLE.
REQ-025 o_mem_wr_en and o_mem_rd_en SHALL never be high in the same cycle.
REQ-026 Address SHALL wrap modulo 2^ADDR_WIDTH; for example, start 8'hFE with length 3 gives FE, FF, 00.
REQ-027 Length SHALL be unsigned, with maximum 2^LEN_WIDTH - 1 beats.
REQ-028 Commands presented while busy SHALL be ignored (o_cmd_ready = 0); no queueing.
REQ-029 Latency from command accept to the first memory access SHALL be 1 cycle.
REQ-030 Write-burst completion: o_done SHALL assert 1 cycle after the last write beat.
REQ-031 Read-burst completion: o_done SHALL assert 2 cycles after the last o_mem_rd_en.

Reset
REQ-032 Asserting i_rst_n low SHALL immediately force: state = IDLE; o_busy, o_done, o_rdata_valid, o_mem_wr_en, o_mem_rd_en = 0; o_mem_address, internal address and count = 0.
REQ-033 After reset, o_cmd_ready SHALL be 1.
REQ-034 Reset during a burst SHALL abort it with no o_done and no further memory access; in-flight read data is discarded.
REQ-035 Deassertion SHALL take effect on the next i_clk rising edge.

Structure
REQ-036 Package burst_mem_pkg SHALL hold the state enumeration and the default widths (DATA_WIDTH, ADDR_WIDTH, LEN_WIDTH).
REQ-037 SHALL be a single flat module; no sub-module is needed.
REQ-038 Read-valid tracking SHALL be a 1-bit register delaying o_mem_rd_en.

Verification
REQ-039 Write burst: addr 8'h01, len 8, data 8'hA0..A7 streamed continuously -> wr_en high 8 consecutive cycles at addresses 01..08; o_done 1 cycle after the last beat.
REQ-040 Read burst: addr 8'h01, len 8 after the REQ-039 write -> rd_en for 8 cycles; o_rdata_valid 8 cycles carrying A0..A7; o_done 2 cycles after the last rd_en.
REQ-041 Write stall: len 4 with i_wdata_valid low for 2 cycles mid-burst -> exactly 4 wr_en pulses at consecutive addresses; no address skip.
REQ-042 Wrap: read at addr 8'hFE, len 3 -> addresses FE, FF, 00.
REQ-043 Zero length: len 0 -> no wr_en or rd_en; o_done 1 cycle after accept.
REQ-044 Reset mid-burst: i_rst_n low during beat 3 of a len-10 read -> all outputs 0 immediately; no o_done; o_cmd_ready = 1 after release.
